// File: rtl/imem_access_ctrl.sv
// Instruction memory port controller.
// Gives the program loader the single memory port until the image is
// complete (LOAD). After that (RUN), CPU fetches have priority, and the
// starvation counter bounds how long a pending loader write can wait.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_LOAD | loader owns the port, CPU held, fetches ignored
// S_RUN  | fetches have priority, loader forced through after starvation
module imem_access_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_hold,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              ld_ack,
    output logic [ADDR_W:0]   ld_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    // STARVE_LIMIT is at most 15, so a 4-bit counter always suffices
    localparam int              SW        = 4;
    localparam logic [SW-1:0]   LIMIT     = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t        state;
    logic [SW-1:0] starve;
    logic          ld_grant;
    logic          fetch_grant;

    // Port arbitration for the current cycle
    always_comb begin
        ld_grant    = 1'b0;
        fetch_grant = 1'b0;
        if (state == S_LOAD) begin
            ld_grant = ld_req;
        end else begin
            ld_grant    = ld_req && (!fetch_req || (starve == LIMIT));
            fetch_grant = fetch_req && !ld_grant;
        end
    end

    // Memory port drive; a write in a reset cycle is dropped and not acked
    always_comb begin
        mem_we    = ld_grant && !reset;
        ld_ack    = ld_grant && !reset;
        mem_wdata = ld_data;
        if (ld_grant) begin
            mem_addr = ld_addr;
        end else if (state == S_RUN) begin
            mem_addr = fetch_addr;
        end else begin
            mem_addr = '0;
        end
    end

    // State machine with registered fetch response, write count and starve counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_LOAD;
            cpu_hold    <= 1'b1;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            ld_count    <= '0;
            starve      <= '0;
        end else begin
            fetch_valid <= fetch_grant;
            if (fetch_grant) begin
                fetch_data <= mem_rdata;
            end
            if (ld_grant && (ld_count != COUNT_MAX)) begin
                ld_count <= ld_count + 1'b1;
            end
            if (state == S_LOAD) begin
                starve <= '0;
                if (ld_done) begin
                    state    <= S_RUN;
                    cpu_hold <= 1'b0;
                end
            end else begin
                cpu_hold <= 1'b0;
                if (ld_req && !ld_grant) begin
                    if (starve != LIMIT) begin
                        starve <= starve + 1'b1;
                    end
                end else begin
                    starve <= '0;
                end
            end
        end
    end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequences and arbitrates the single port of the 1024x32 instruction memory between two requesters: the CPU fetch unit and a program loader that writes the program image.
- After reset it holds the CPU in LOAD state while the loader fills the memory. It then switches to RUN state, where fetches have priority and loader writes are serviced with bounded starvation.
- Sits between the fetch stage, the loader, and the instruction memory.

Parameters:
- ADDR_W, 10, instruction memory address width.
- DATA_W, 32, instruction word width.
- STARVE_LIMIT, 4, consecutive RUN cycles a pending loader write may be blocked by fetches before it is forced through (range 1..15).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  CPU requests an instruction word.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_valid  out  1  fetch_data is valid for the request granted the previous cycle.
- fetch_data  out  DATA_W  registered instruction word.
- cpu_hold  out  1  CPU must stall; high in LOAD state.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDR_W  loader write address.
- ld_data  in  DATA_W  loader write data.
- ld_done  in  1  loader signals image complete.
- ld_ack  out  1  loader write performed this cycle.
- ld_count  out  ADDR_W+1  number of writes acknowledged since reset (saturating).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory combinational read data for mem_addr.

Behaviour:
- States: LOAD and RUN. Reset forces LOAD.
- Reset values: fetch_valid=0, fetch_data=0, cpu_hold=1, ld_ack=0, ld_count=0, starve counter=0. The mem_* outputs are driven by the current-state combinational logic, so after reset mem_we=0 and mem_addr=0 unless ld_req is high.
- LOAD:
  - cpu_hold=1 and fetch_req is ignored; fetch_valid stays 0.
  - When ld_req=1: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, ld_ack=1 in the same cycle (combinational ack, write committed at that clock edge).
  - When ld_done=1, the next state is RUN. If ld_req and ld_done are both high in the same cycle, the write is still performed and acked.
- RUN:
  - cpu_hold=0.
  - Grant rule: loader is granted if ld_req=1 and (fetch_req=0 or starve counter == STARVE_LIMIT). Otherwise fetch is granted if fetch_req=1. With no requests, mem_we=0 and mem_addr=fetch_addr.
  - Fetch grant: mem_addr=fetch_addr, mem_we=0. On the next edge fetch_data<=mem_rdata and fetch_valid<=1. Latency is 1 cycle.
  - Any cycle without a fetch grant gives fetch_valid=0 next cycle, and fetch_data holds its value.
  - Loader grant: identical to a LOAD write, and ld_ack=1. A write cycle never produces fetch_valid on the following cycle. The CPU must keep fetch_req/fetch_addr asserted until it observes fetch_valid.
  - Starve counter: increments when ld_req=1 and the fetch is granted instead. It is cleared on a loader grant or when ld_req=0, and it saturates at STARVE_LIMIT.
  - ld_done is ignored in RUN. There is no return to LOAD except through reset.
- ld_count increments on every ld_ack cycle, saturating at 2^ADDR_W.
- Rewriting the same address is allowed; the last write wins.
- Reset asserted mid-operation: the next state is LOAD, all registers return to reset values, and the ack for any pending write that cycle is suppressed (mem_we=0 while reset=1).
- Address wrap-around is not performed by this block; addresses pass through unchanged.

Test Plan:
- Reset, then ld_req writes words 0x54100000 @0 and 0x58000000 @1 with ld_done on the 2nd write -> ld_ack=1 both cycles, ld_count=2, cpu_hold falls the cycle after ld_done.
- RUN, fetch_req=1 addr=1 with mem_rdata=0x58000000 -> next cycle fetch_valid=1, fetch_data=0x58000000.
- RUN, fetch_req held continuously and ld_req=1 @addr 5 with STARVE_LIMIT=4 -> 4 fetch grants, then a loader grant on the 5th cycle (ld_ack=1, mem_we=1, addr 5), then fetch_valid=0 for one cycle and fetches resume.
- RUN, ld_req=1 and fetch_req=0 -> immediate ld_ack, counter stays 0.
- LOAD with fetch_req=1 -> cpu_hold=1, fetch_valid never asserts, mem_we only with ld_req.
- Reset asserted in RUN during a loader write -> mem_we=0, ld_ack=0 that cycle; then cpu_hold=1, ld_count=0, fetch_valid=0.
